// File: rtl/pool2d_stream_if.sv
// Ready/valid stream bundle for the 2x2 pooling stage: sample input side and pooled output side.
interface pool2d_stream_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH_W   = 1
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] pixel_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_last;

  modport slave (
    input  in_valid, pixel_in, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last
  );

  modport master (
    output in_valid, pixel_in, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last
  );
endinterface

// File: rtl/pool2d_stream.sv
// Streaming 2x2 stride-2 max/average pooling over a raster-order, channel-interleaved frame.
// Horizontal pairs of even rows are parked in a line buffer until the odd row completes each quad.
module pool2d_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 4,
  parameter int unsigned IMG_H  = 4,
  parameter int unsigned CH     = 1,
  parameter int unsigned CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  pool2d_stream_if.slave    io
);

  localparam int unsigned SUM_W    = DATA_W + 2;
  localparam int unsigned HALF_W   = IMG_W / 2;
  localparam int unsigned LB_DEPTH = HALF_W * CH;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int unsigned COL_W    = $clog2(IMG_W);
  localparam int unsigned ROW_W    = $clog2(IMG_H);

  logic [CH_W-1:0]           ch_q, ch_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic                      mode_q, mode_d;
  logic signed [SUM_W-1:0]   hold_q [CH];
  logic signed [SUM_W-1:0]   hold_d [CH];
  logic signed [SUM_W-1:0]   lb_q   [LB_DEPTH];

  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]           out_ch_q, out_ch_d;
  logic                      out_last_q, out_last_d;

  logic                      in_ready_c;
  logic                      accept_c;
  logic                      ch_last_c, col_last_c, row_last_c;
  logic [LB_AW-1:0]          lb_addr_c;
  logic                      lb_we_c;
  logic signed [SUM_W-1:0]   pix_ext_c;
  logic signed [SUM_W-1:0]   partner_c;
  logic signed [SUM_W-1:0]   comb_c;
  logic signed [SUM_W-1:0]   avg_c;
  logic signed [DATA_W-1:0]  result_c;
  logic                      load_c;

  assign in_ready_c   = !out_valid_q || io.out_ready;
  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_ch    = out_ch_q;
  assign io.out_last  = out_last_q;

  // Position decode, operand selection and the max/sum combiner.
  always_comb begin
    accept_c   = io.in_valid && in_ready_c;
    ch_last_c  = (ch_q  == CH_W'(CH - 1));
    col_last_c = (col_q == COL_W'(IMG_W - 1));
    row_last_c = (row_q == ROW_W'(IMG_H - 1));
    lb_addr_c  = LB_AW'((32'(col_q) >> 1) * CH + 32'(ch_q));
    pix_ext_c  = {{2{io.pixel_in[DATA_W-1]}}, io.pixel_in};
    partner_c  = (row_q[0] && !col_q[0]) ? lb_q[lb_addr_c] : hold_q[ch_q];
    if (mode_q) begin
      comb_c = partner_c + pix_ext_c;
    end else begin
      comb_c = (partner_c > pix_ext_c) ? partner_c : pix_ext_c;
    end
    avg_c    = comb_c >>> 2;
    result_c = mode_q ? avg_c[DATA_W-1:0] : comb_c[DATA_W-1:0];
  end

  // Counter advance, frame-start mode capture, partial-result routing and output register.
  always_comb begin
    ch_d        = ch_q;
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    hold_d      = hold_q;
    lb_we_c     = 1'b0;
    load_c      = 1'b0;
    out_valid_d = out_valid_q && !io.out_ready;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;

    if (accept_c) begin
      if (ch_q == '0 && col_q == '0 && row_q == '0) begin
        mode_d = mode;
      end
      if (ch_last_c) begin
        ch_d = '0;
        if (col_last_c) begin
          col_d = '0;
          row_d = row_last_c ? '0 : row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end else begin
        ch_d = ch_q + CH_W'(1);
      end

      unique case ({row_q[0], col_q[0]})
        2'b00:   hold_d[ch_q] = pix_ext_c;
        2'b01:   lb_we_c      = 1'b1;
        2'b10:   hold_d[ch_q] = comb_c;
        default: load_c       = 1'b1;
      endcase
    end

    if (load_c) begin
      out_valid_d = 1'b1;
      out_data_d  = result_c;
      out_ch_d    = ch_q;
      out_last_d  = ch_last_c && col_last_c && row_last_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < int'(CH); i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      ch_q        <= ch_d;
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      hold_q      <= hold_d;
    end
  end

  // Line buffer needs no reset: every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we_c) begin
      lb_q[lb_addr_c] <= comb_c;
    end
  end

endmodule
